// File: rtl/mandel_pkg.sv
// Shared types and defaults for the Mandelbrot pixel dispatcher.
package mandel_pkg;
    localparam int Q_W      = 25;
    localparam int FRAC_DEF = 22;
    localparam int FB_W_DEF = 320;
    localparam int FB_H_DEF = 240;

    typedef logic [11:0]          rgb444_t;
    typedef logic signed [Q_W-1:0] qcoord_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_WRITE
    } disp_state_t;
endpackage

// File: rtl/mandel_coord_step.sv
// Raster walker: holds the current complex-plane coordinate, pixel/row
// counters and the running framebuffer address for the dispatcher.
module mandel_coord_step
    import mandel_pkg::*;
#(
    parameter int FB_W   = FB_W_DEF,
    parameter int FB_H   = FB_H_DEF,
    parameter int ADDR_W = 17
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_load,
    input  logic                  i_advance,
    input  logic signed [Q_W-1:0] i_center_x,
    input  logic signed [Q_W-1:0] i_center_y,
    input  logic signed [Q_W-1:0] i_step,
    output logic signed [Q_W-1:0] o_cx,
    output logic signed [Q_W-1:0] o_cy,
    output logic [ADDR_W-1:0]     o_addr,
    output logic                  o_last
);
    localparam int PX_W = (FB_W > 1) ? $clog2(FB_W) : 1;
    localparam int PY_W = (FB_H > 1) ? $clog2(FB_H) : 1;
    localparam logic signed [Q_W-1:0] HALF_W = Q_W'(FB_W / 2);
    localparam logic signed [Q_W-1:0] HALF_H = Q_W'(FB_H / 2);

    qcoord_t         w_x_off, w_y_off;
    qcoord_t         r_x0, r_step, r_cx, r_cy;
    logic [PX_W-1:0] r_px;
    logic [PY_W-1:0] r_py;
    logic [ADDR_W-1:0] r_addr;
    logic            w_row_end;

    // Constant multiplies, truncated to Q_W bits so the origin wraps like every other add.
    assign w_x_off   = i_step * HALF_W;
    assign w_y_off   = i_step * HALF_H;
    assign w_row_end = (r_px == PX_W'(FB_W - 1));

    assign o_last = w_row_end && (r_py == PY_W'(FB_H - 1));
    assign o_cx   = r_cx;
    assign o_cy   = r_cy;
    assign o_addr = r_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x0   <= '0;
            r_step <= '0;
            r_cx   <= '0;
            r_cy   <= '0;
            r_px   <= '0;
            r_py   <= '0;
            r_addr <= '0;
        end else if (i_load) begin
            r_step <= i_step;
            r_x0   <= i_center_x - w_x_off;
            r_cx   <= i_center_x - w_x_off;
            r_cy   <= i_center_y + w_y_off;
            r_px   <= '0;
            r_py   <= '0;
            r_addr <= '0;
        end else if (i_advance && !o_last) begin
            r_addr <= r_addr + ADDR_W'(1);
            if (w_row_end) begin
                r_px <= '0;
                r_cx <= r_x0;
                r_py <= r_py + PY_W'(1);
                r_cy <= r_cy - r_step;
            end else begin
                r_px <= r_px + PX_W'(1);
                r_cx <= r_cx + r_step;
            end
        end
    end
endmodule

// File: rtl/mandel_pixel_dispatch.sv
// Frame sequencer: walks the framebuffer, hands each pixel coordinate to the
// iteration core and writes the returned colour back.
module mandel_pixel_dispatch
    import mandel_pkg::*;
#(
    parameter int FB_W   = FB_W_DEF,
    parameter int FB_H   = FB_H_DEF,
    parameter int FRAC   = FRAC_DEF,
    parameter int ADDR_W = 17
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  frame_start,
    input  logic signed [Q_W-1:0] center_x,
    input  logic signed [Q_W-1:0] center_y,
    input  logic signed [Q_W-1:0] step,
    output logic                  frame_busy,
    output logic                  frame_done,
    output logic                  core_start,
    output logic signed [Q_W-1:0] core_cx,
    output logic signed [Q_W-1:0] core_cy,
    input  logic                  core_busy,
    input  logic                  core_done,
    input  logic [11:0]           core_rgb,
    output logic                  fb_we,
    output logic [ADDR_W-1:0]     fb_addr,
    output logic [11:0]           fb_wdata
);
    if (FRAC < 1 || FRAC >= Q_W) begin : g_frac_chk
        $error("FRAC must lie within the coordinate width");
    end
    if ((64'd1 << ADDR_W) < 64'(FB_W * FB_H)) begin : g_addr_chk
        $error("ADDR_W too small for FB_W*FB_H");
    end

    disp_state_t r_state, w_state_d;
    logic        w_load, w_issue, w_capture, w_advance, w_last;
    logic        r_core_start, r_fb_we, r_frame_done, r_frame_busy;
    rgb444_t     r_wdata;

    mandel_coord_step #(
        .FB_W   (FB_W),
        .FB_H   (FB_H),
        .ADDR_W (ADDR_W)
    ) u_step (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_advance  (w_advance),
        .i_center_x (center_x),
        .i_center_y (center_y),
        .i_step     (step),
        .o_cx       (core_cx),
        .o_cy       (core_cy),
        .o_addr     (fb_addr),
        .o_last     (w_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_d;
    end

    // core_done seen outside WAIT belongs to a pixel aborted by reset and is dropped.
    always_comb begin
        w_state_d = r_state;
        w_load    = 1'b0;
        w_issue   = 1'b0;
        w_capture = 1'b0;
        w_advance = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (frame_start) begin
                    w_load    = 1'b1;
                    w_state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!core_busy) begin
                    w_issue   = 1'b1;
                    w_state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (core_done) begin
                    w_capture = 1'b1;
                    w_state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                w_advance = 1'b1;
                w_state_d = w_last ? ST_IDLE : ST_ISSUE;
            end
            default: w_state_d = ST_IDLE;
        endcase
    end

    // Strobes are registered, so each lands one cycle after its decision and
    // the three never coincide: start in first WAIT, we in WRITE, done in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_core_start <= 1'b0;
            r_fb_we      <= 1'b0;
            r_frame_done <= 1'b0;
            r_frame_busy <= 1'b0;
            r_wdata      <= '0;
        end else begin
            r_core_start <= w_issue;
            r_fb_we      <= w_capture;
            r_frame_done <= w_advance && w_last;
            if (w_capture)
                r_wdata <= core_rgb;
            if (w_load)
                r_frame_busy <= 1'b1;
            else if (w_advance && w_last)
                r_frame_busy <= 1'b0;
        end
    end

    assign core_start = r_core_start;
    assign fb_we      = r_fb_we;
    assign frame_done = r_frame_done;
    assign frame_busy = r_frame_busy;
    assign fb_wdata   = r_wdata;
endmodule

// File: tb/tb_mandel_pixel_dispatch.sv
// Directed bench for mandel_pixel_dispatch on a 4x2 framebuffer with a
// fixed-latency core model.
module tb_mandel_pixel_dispatch;
    localparam int W  = 4;
    localparam int H  = 2;
    localparam int AW = 3;

    logic clk = 1'b0, rst_n = 1'b0, frame_start = 1'b0;
    logic signed [24:0] center_x = '0, center_y = '0, step = '0;
    logic frame_busy, frame_done, core_start, core_busy, core_done, fb_we;
    logic signed [24:0] core_cx, core_cy;
    logic [11:0] core_rgb, fb_wdata;
    logic [AW-1:0] fb_addr;

    mandel_pixel_dispatch #(.FB_W(W), .FB_H(H), .FRAC(22), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
        .center_x(center_x), .center_y(center_y), .step(step),
        .frame_busy(frame_busy), .frame_done(frame_done),
        .core_start(core_start), .core_cx(core_cx), .core_cy(core_cy),
        .core_busy(core_busy), .core_done(core_done), .core_rgb(core_rgb),
        .fb_we(fb_we), .fb_addr(fb_addr), .fb_wdata(fb_wdata)
    );

    always #5 clk = ~clk;

    // Core model: done arrives 5 cycles after the start cycle; rgb = 0x100 + start index.
    int m_cnt = 0, m_starts = 0;
    logic m_hold = 1'b0;
    logic [11:0] m_rgb = '0;
    assign core_busy = (m_cnt != 0) || m_hold;
    assign core_done = (m_cnt == 1);
    assign core_rgb  = m_rgb;
    initial forever begin
        @(negedge clk);
        if (core_start) begin
            m_cnt    = 6;
            m_rgb    = 12'h100 + 12'(m_starts);
            m_starts = m_starts + 1;
        end else if (m_cnt != 0) begin
            m_cnt = m_cnt - 1;
        end
    end

    // Monitor, sampling just after each rising edge.
    int cyc = 0, n_done = 0, done_cyc = 0, n_overlap = 0, n_x = 0;
    int fb_cyc[$], st_cyc[$];
    logic [AW-1:0] fb_addr_q[$];
    logic [11:0]   fb_data_q[$];
    logic [24:0]   st_cx[$], st_cy[$];
    initial forever begin
        @(posedge clk);
        #1;
        cyc = cyc + 1;
        if (fb_we) begin
            fb_cyc.push_back(cyc);
            fb_addr_q.push_back(fb_addr);
            fb_data_q.push_back(fb_wdata);
        end
        if (core_start) begin
            st_cyc.push_back(cyc);
            st_cx.push_back(core_cx);
            st_cy.push_back(core_cy);
        end
        if (frame_done) begin
            n_done   = n_done + 1;
            done_cyc = cyc;
        end
        if (int'(fb_we) + int'(core_start) + int'(frame_done) > 1) n_overlap = n_overlap + 1;
        if (rst_n && $isunknown({frame_busy, frame_done, core_start, core_cx, core_cy,
                                 fb_we, fb_addr, fb_wdata})) n_x = n_x + 1;
    end

    int n_chk = 0, n_fail = 0;
    logic [24:0] e_cx[4];
    logic [24:0] e_cy[2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_q();
        fb_cyc.delete(); st_cyc.delete(); fb_addr_q.delete();
        fb_data_q.delete(); st_cx.delete(); st_cy.delete();
    endtask

    task automatic launch(input logic [24:0] cx, input logic [24:0] cy, input logic [24:0] st,
                          output int fcyc);
        @(negedge clk);
        center_x = cx; center_y = cy; step = st; frame_start = 1'b1;
        fcyc = cyc;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic wait_done(input int prev, input string tag);
        int k = 0;
        while (n_done == prev && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(n_done != prev), 32'd1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"},  32'(frame_busy), 32'd0);
        chk({tag, "_done"},  32'(frame_done), 32'd0);
        chk({tag, "_start"}, 32'(core_start), 32'd0);
        chk({tag, "_we"},    32'(fb_we),      32'd0);
        chk({tag, "_cx"},    {7'd0, core_cx}, 32'd0);
        chk({tag, "_cy"},    {7'd0, core_cy}, 32'd0);
        chk({tag, "_addr"},  32'(fb_addr),    32'd0);
        chk({tag, "_wdata"}, 32'(fb_wdata),   32'd0);
    endtask

    task automatic check_frame(input string tag, input logic [11:0] rgb0);
        chk({tag, "_nwr"},   fb_addr_q.size(), 32'd8);
        chk({tag, "_nstart"}, st_cx.size(),    32'd8);
        if (fb_addr_q.size() == 8 && st_cx.size() == 8) begin
            for (int k = 0; k < 8; k++) begin
                chk($sformatf("%s_addr%0d", tag, k),  32'(fb_addr_q[k]), 32'(k));
                chk($sformatf("%s_wdata%0d", tag, k), 32'(fb_data_q[k]), 32'(rgb0) + 32'(k));
                chk($sformatf("%s_cx%0d", tag, k),    32'(st_cx[k]),     32'(e_cx[k % 4]));
                chk($sformatf("%s_cy%0d", tag, k),    32'(st_cy[k]),     32'(e_cy[k / 4]));
            end
        end
    endtask

    initial begin
        int f, nd, rel;

        cycles(2);
        chk_zero("rst");
        @(negedge clk);
        rst_n = 1'b1;
        cycles(2);

        // Frame 1: centre (0,0), step 0.25
        e_cx = '{25'h1E00000, 25'h1F00000, 25'h0000000, 25'h0100000};
        e_cy = '{25'h0100000, 25'h0000000};
        clear_q();
        nd = n_done;
        launch(25'h0, 25'h0, 25'h0100000, f);
        chk("f1_busy", 32'(frame_busy), 32'd1);
        wait_done(nd, "f1_done_seen");
        check_frame("f1", 12'h100);
        if (st_cyc.size() > 0) chk("f1_first_start_cyc", 32'(st_cyc[0]), 32'(f + 2));
        if (fb_cyc.size() == 8) begin
            for (int k = 0; k < 7; k++)
                chk($sformatf("f1_gap%0d", k), 32'(fb_cyc[k+1] - fb_cyc[k]), 32'd8);
            chk("f1_done_cyc", 32'(done_cyc), 32'(fb_cyc[7] + 1));
        end
        chk("f1_busy_clr", 32'(frame_busy), 32'd0);
        chk("f1_ndone", 32'(n_done - nd), 32'd1);

        // Frame 2: core busy at frame start
        clear_q();
        m_hold = 1'b1;
        nd = n_done;
        launch(25'h0, 25'h0, 25'h0100000, f);
        cycles(9);
        chk("f2_no_start_held", st_cyc.size(), 32'd0);
        chk("f2_busy_held", 32'(frame_busy), 32'd1);
        rel = cyc;
        m_hold = 1'b0;
        wait_done(nd, "f2_done_seen");
        if (st_cyc.size() > 0) chk("f2_start_after_rel", 32'(st_cyc[0]), 32'(rel + 1));
        check_frame("f2", 12'h108);

        // Frame 3: wrapping coordinates, mid-frame frame_start with new centre
        e_cx = '{25'h07FFFFF, 25'h0BFFFFF, 25'h0FFFFFF, 25'h13FFFFF};
        e_cy = '{25'h13FFFFF, 25'h0FFFFFF};
        clear_q();
        nd = n_done;
        launch(25'h0FFFFFF, 25'h0FFFFFF, 25'h0400000, f);
        for (int k = 0; k < 200 && fb_addr_q.size() < 2; k++) @(negedge clk);
        center_x = '0; center_y = '0; step = 25'h0100000; frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        wait_done(nd, "f3_done_seen");
        cycles(20);
        chk("f3_one_done", 32'(n_done - nd), 32'd1);
        chk("f3_busy_clr", 32'(frame_busy), 32'd0);
        check_frame("f3", 12'h110);

        // Frame 4: reset while waiting on pixel 3, stale done after release
        e_cx = '{25'h1E00000, 25'h1F00000, 25'h0000000, 25'h0100000};
        e_cy = '{25'h0100000, 25'h0000000};
        clear_q();
        launch(25'h0, 25'h0, 25'h0100000, f);
        for (int k = 0; k < 200 && st_cyc.size() < 4; k++) @(negedge clk);
        chk("f4_px3_started", st_cyc.size(), 32'd4);
        @(negedge clk);
        chk("f4_busy_pre_rst", 32'(frame_busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_zero("midrst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        clear_q();
        nd = n_done;
        center_x = '0; center_y = '0; step = 25'h0100000; frame_start = 1'b1;
        f = cyc;
        @(negedge clk);
        frame_start = 1'b0;
        wait_done(nd, "f4_done_seen");
        if (st_cyc.size() > 0) chk("f4_first_start_cyc", 32'(st_cyc[0]), 32'(f + 4));
        check_frame("f4", 12'h11C);
        chk("f4_ndone", 32'(n_done - nd), 32'd1);

        chk("no_overlap", 32'(n_overlap), 32'd0);
        chk("no_x", 32'(n_x), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
